// File: rtl/vga_pkg.sv
// Shared VGA constants, the pixel record and the arbiter state type used by
// the write arbiter, its pacer and its bus interface.
package vga_pkg;

    localparam int VGA_X_W   = 8;
    localparam int VGA_Y_W   = 7;
    localparam int VGA_COL_W = 18;
    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;

    typedef struct packed {
        logic [VGA_X_W-1:0]   x;
        logic [VGA_Y_W-1:0]   y;
        logic [VGA_COL_W-1:0] colour;
    } pixel_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    // True when the pixel lands inside the visible 160x120 frame.
    function automatic logic on_screen(input pixel_t pix);
        return (int'(pix.x) < SCREEN_W) && (int'(pix.y) < SCREEN_H);
    endfunction

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Requester-side handshake and VGA write port bundle; the drawers sit on the
// master modport and the arbiter on the slave modport.
interface vga_write_arbiter_if
    import vga_pkg::*;
#(
    parameter int NUM_REQ = 3
);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ*VGA_X_W-1:0]   req_x;
    logic [NUM_REQ*VGA_Y_W-1:0]   req_y;
    logic [NUM_REQ*VGA_COL_W-1:0] req_colour;
    logic [NUM_REQ-1:0]           req_ready;

    logic [VGA_X_W-1:0]           vga_x;
    logic [VGA_Y_W-1:0]           vga_y;
    logic [VGA_COL_W-1:0]         vga_colour;
    logic                         vga_write;
    logic                         window_open;
    logic                         frame_tick;

    modport master (
        output req_valid, req_last, req_x, req_y, req_colour,
        input  req_ready, vga_x, vga_y, vga_colour, vga_write,
               window_open, frame_tick
    );

    modport slave (
        input  req_valid, req_last, req_x, req_y, req_colour,
        output req_ready, vga_x, vga_y, vga_colour, vga_write,
               window_open, frame_tick
    );

endinterface

// File: rtl/vga_write_arbiter_frame_pacer.sv
// Frame pacer: a free-running down-counter that opens a write window for the
// last WINDOW cycles of every FRAME_PERIOD-cycle period.
module frame_pacer #(
    parameter int FRAME_PERIOD = 1700000,
    parameter int WINDOW       = 1200
) (
    input  logic clock,
    input  logic reset,
    output logic window_open,
    output logic frame_tick
);

    localparam int CNT_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= CNT_LAST;
        end else if (cnt == '0) begin
            cnt <= CNT_LAST;
        end else begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Compared at 32 bits so WINDOW == FRAME_PERIOD still fits.
    always_comb begin
        window_open = (32'(cnt) < 32'(WINDOW));
        frame_tick  = (32'(cnt) == 32'(WINDOW - 1));
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin burst arbiter for the VGA adapter write port, paced by a frame
// write window. Define VGA_ARB_CLIP_EN to drop off-screen pixels silently.
module vga_write_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int FRAME_PERIOD = 1700000,
    parameter int WINDOW       = 1200
) (
    input  logic                clock,
    input  logic                reset,
    vga_write_arbiter_if.slave  bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t        state;
    logic [PTR_W-1:0]  owner;
    logic [PTR_W-1:0]  rr_ptr;
    logic              window_open;
    logic              pick_found;
    logic [PTR_W-1:0]  pick_idx;
    logic              grant_ready;
    logic              transfer;
    logic              write_en;
    pixel_t            owner_pix;

    frame_pacer #(
        .FRAME_PERIOD (FRAME_PERIOD),
        .WINDOW       (WINDOW)
    ) u_pacer (
        .clock       (clock),
        .reset       (reset),
        .window_open (window_open),
        .frame_tick  (bus.frame_tick)
    );

    assign bus.window_open = window_open;

    // Scan downward so the valid requester closest to rr_ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        owner_pix.x      = bus.req_x[int'(owner)*VGA_X_W +: VGA_X_W];
        owner_pix.y      = bus.req_y[int'(owner)*VGA_Y_W +: VGA_Y_W];
        owner_pix.colour = bus.req_colour[int'(owner)*VGA_COL_W +: VGA_COL_W];
    end

    // Ready depends only on state, owner and the pacer, never on valid.
    always_comb begin
        grant_ready   = (state == ARB_GRANT) && window_open;
        bus.req_ready = '0;
        if (grant_ready) begin
            bus.req_ready[owner] = 1'b1;
        end
        transfer = grant_ready && bus.req_valid[owner];
`ifdef VGA_ARB_CLIP_EN
        write_en = transfer && on_screen(owner_pix);
`else
        write_en = transfer;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= ARB_IDLE;
            owner          <= '0;
            rr_ptr         <= '0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
            bus.vga_write  <= 1'b0;
        end else begin
            bus.vga_write <= write_en;
            if (write_en) begin
                bus.vga_x      <= owner_pix.x;
                bus.vga_y      <= owner_pix.y;
                bus.vga_colour <= owner_pix.colour;
            end
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        state <= ARB_GRANT;
                        owner <= pick_idx;
                    end
                end
                ARB_GRANT: begin
                    if (transfer && bus.req_last[owner]) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= (int'(owner) == NUM_REQ - 1) ? '0 : owner + PTR_W'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
